// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM states, parity modes and oversample timing.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Majority-vote sample points inside one 16-tick bit period.
  localparam logic [3:0] TICK_S1   = 4'd7;
  localparam logic [3:0] TICK_S2   = 4'd8;
  localparam logic [3:0] TICK_S3   = 4'd9;
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchronizer plus 3-sample majority voter for the UART receiver.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       bclk,
  input  logic       rst_n,
  input  logic       i_rxd,
  input  logic [3:0] i_tick,
  output logic       o_rxs,
  output logic       o_vote
);

  logic r_sync1;
  logic r_sync2;
  logic r_s1;
  logic r_s2;

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      if (i_tick == TICK_S1) r_s1 <= r_sync2;
      if (i_tick == TICK_S2) r_s2 <= r_sync2;
    end
  end

  // Vote is meaningful during the third sample tick; the live value is the third sample.
  assign o_rxs  = r_sync2;
  assign o_vote = (r_s1 & r_s2) | (r_s1 & r_sync2) | (r_s2 & r_sync2);

endmodule

// File: rtl/uart_rx_ext.sv
// 16x-oversampling UART receiver with parity/stop checking and a valid/ready output.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 bclk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  rx_state_t            r_state;
  logic [3:0]           r_tick;
  logic [3:0]           r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_fe_pend;
  logic                 r_perr_pend;
  logic                 r_busy;
  logic                 r_valid;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_ferr;
  logic                 r_perr;
  logic                 r_overrun;

  logic w_rxs;
  logic w_vote;
  logic w_last_stop;
  logic w_done;
  logic w_fe_final;
  logic w_par_calc;
  logic w_perr_bit;

  uart_rx_sampler u_sampler (
    .bclk   (bclk),
    .rst_n  (rst_n),
    .i_rxd  (rxd),
    .i_tick (r_tick),
    .o_rxs  (w_rxs),
    .o_vote (w_vote)
  );

  always_comb begin
    w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
    w_done      = (r_state == ST_STOP) && (r_tick == TICK_S3) && w_last_stop;
    w_fe_final  = r_fe_pend | ~w_vote;
    w_par_calc  = (^r_shift) ^ w_vote;
    w_perr_bit  = (PARITY == PAR_ODD) ? ~w_par_calc : w_par_calc;
  end

  // The IDLE cycle that first sees rxs low is tick 0 of the start bit.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tick      <= '0;
      r_bit_cnt   <= '0;
      r_stop_cnt  <= 1'b0;
      r_shift     <= '0;
      r_fe_pend   <= 1'b0;
      r_perr_pend <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tick <= r_tick + 4'd1;
      case (r_state)
        ST_IDLE: begin
          r_tick <= '0;
          if (!w_rxs) begin
            r_state     <= ST_START;
            r_tick      <= 4'd1;
            r_busy      <= 1'b1;
            r_fe_pend   <= 1'b0;
            r_perr_pend <= 1'b0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
          end
        end
        ST_START: begin
          if ((r_tick == TICK_S3) && w_vote) begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
            r_busy  <= 1'b0;
          end else if (r_tick == TICK_LAST) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_tick == TICK_S3) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (r_tick == TICK_LAST) begin
            if (r_bit_cnt == 4'(DATA_BITS - 1))
              r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            else
              r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        ST_PARITY: begin
          if (r_tick == TICK_S3) r_perr_pend <= w_perr_bit;
          if (r_tick == TICK_LAST) r_state <= ST_STOP;
        end
        ST_STOP: begin
          if (r_tick == TICK_S3) begin
            if (w_last_stop) begin
              // Finish early so the next start edge is caught promptly.
              r_tick <= '0;
              if (w_fe_final) begin
                r_state <= ST_BRK_WAIT;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_fe_pend <= w_fe_final;
            end
          end else if (r_tick == TICK_LAST) begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end
        end
        ST_BRK_WAIT: begin
          r_tick <= '0;
          if (w_rxs) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tick  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Handshake: a word transfers on any cycle with m_valid && m_ready; m_data and flags
  // stay stable while m_valid is high, and a frame finishing against a stalled word is dropped.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && m_ready) r_valid <= 1'b0;
      if (w_done) begin
        if (!r_valid || m_ready) begin
          r_valid <= 1'b1;
          r_data  <= r_shift;
          r_ferr  <= w_fe_final;
          r_perr  <= (PARITY != PAR_NONE) && r_perr_pend;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign m_valid    = r_valid;
  assign m_data     = r_data;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign overrun    = r_overrun;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: three instances (8N1, 7E1, 8N2) driven with serial frames.
module tb_uart_rx_ext;
  import uart_pkg::*;

  logic bclk = 1'b0;
  always #5 bclk = ~bclk;

  logic rst_n;
  logic rxd_a[3];
  logic rdy_a[3];

  logic       v0, v1, v2, fe0, fe1, fe2, pe0, pe1, pe2, ov0, ov1, ov2, bz0, bz1, bz2;
  logic [2:0] st0, st1, st2;
  logic [7:0] md0, md2;
  logic [6:0] md1;

  logic       vld_a[3], fe_a[3], pe_a[3], ov_a[3], bz_a[3];
  logic [2:0] st_a[3];
  logic [8:0] dat_a[3];

  always_comb begin
    vld_a[0] = v0;  vld_a[1] = v1;  vld_a[2] = v2;
    fe_a[0]  = fe0; fe_a[1]  = fe1; fe_a[2]  = fe2;
    pe_a[0]  = pe0; pe_a[1]  = pe1; pe_a[2]  = pe2;
    ov_a[0]  = ov0; ov_a[1]  = ov1; ov_a[2]  = ov2;
    bz_a[0]  = bz0; bz_a[1]  = bz1; bz_a[2]  = bz2;
    st_a[0]  = st0; st_a[1]  = st1; st_a[2]  = st2;
    dat_a[0] = {1'b0, md0};
    dat_a[1] = {2'b00, md1};
    dat_a[2] = {1'b0, md2};
  end

  uart_rx_ext #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .bclk(bclk), .rst_n(rst_n), .rxd(rxd_a[0]), .m_valid(v0), .m_ready(rdy_a[0]),
    .m_data(md0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(bz0), .dbg_state(st0));
  uart_rx_ext #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .bclk(bclk), .rst_n(rst_n), .rxd(rxd_a[1]), .m_valid(v1), .m_ready(rdy_a[1]),
    .m_data(md1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(bz1), .dbg_state(st1));
  uart_rx_ext #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .bclk(bclk), .rst_n(rst_n), .rxd(rxd_a[2]), .m_valid(v2), .m_ready(rdy_a[2]),
    .m_data(md2), .frame_err(fe2), .parity_err(pe2), .overrun(ov2), .busy(bz2), .dbg_state(st2));

  int n_checks = 0;
  int n_errors = 0;

  // Received words as {frame_err, parity_err, data}
  logic [10:0] got_q[3][$];
  logic [10:0] exp_q[$];
  int          ovr_cnt[3];

  always @(negedge bclk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        ovr_cnt[d] <= 0;
      end else begin
        if (vld_a[d] && rdy_a[d]) got_q[d].push_back({fe_a[d], pe_a[d], dat_a[d]});
        if (ov_a[d]) ovr_cnt[d] <= ovr_cnt[d] + 1;
      end
    end
  end

  function automatic int nbits_of(int d);
    return (d == 1) ? 7 : 8;
  endfunction

  function automatic int par_of(int d);
    return (d == 1) ? PAR_EVEN : PAR_NONE;
  endfunction

  function automatic int nstop_of(int d);
    return (d == 2) ? 2 : 1;
  endfunction

  function automatic logic [8:0] mask_of(int d, logic [8:0] data);
    logic [8:0] m;
    m = (9'h1 << nbits_of(d)) - 9'h1;
    return data & m;
  endfunction

  // Correct parity bit: total ones (data + parity) odd for odd mode, even for even mode.
  function automatic logic par_bit(int d, logic [8:0] data);
    logic [8:0] md;
    md = mask_of(d, data);
    return (par_of(d) == PAR_ODD) ? ~(^md) : (^md);
  endfunction

  function automatic logic [10:0] model(int d, logic [8:0] data, bit flip, bit bad_stop);
    logic [8:0] md;
    logic       pb, x, pe;
    md = mask_of(d, data);
    pe = 1'b0;
    if (par_of(d) != PAR_NONE) begin
      pb = par_bit(d, data) ^ flip;
      x  = (^md) ^ pb;
      pe = (par_of(d) == PAR_ODD) ? (x == 1'b0) : (x == 1'b1);
    end
    return {bad_stop, pe, md};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge bclk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input int d, input logic v);
    rxd_a[d] = v;
    step(OVERSAMPLE);
  endtask

  task automatic send_frame(input int d, input logic [8:0] data, input bit flip,
                            input bit bad_stop, input bit keep_low);
    send_bit(d, 1'b0);
    for (int i = 0; i < nbits_of(d); i++) send_bit(d, data[i]);
    if (par_of(d) != PAR_NONE) send_bit(d, par_bit(d, data) ^ flip);
    for (int s = 0; s < nstop_of(d); s++)
      send_bit(d, (bad_stop && s == nstop_of(d) - 1) ? 1'b0 : 1'b1);
    if (!keep_low) rxd_a[d] = 1'b1;
  endtask

  task automatic wait_got(input int d, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (got_q[d].size() > 0) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic expect_word(input string name, input int d, input logic [10:0] exp);
    bit          ok;
    logic [10:0] got;
    wait_got(d, 64, ok);
    check({name, "_arrived"}, 32'(ok), 32'd1);
    if (ok) begin
      got = got_q[d].pop_front();
      check({name, "_word"}, 32'(got), 32'(exp));
    end
  endtask

  typedef struct {
    int          d;
    logic [8:0]  data;
    bit          flip;
    bit          bad;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [10:0] e;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rxd_a[d] = 1'b1;
      rdy_a[d] = 1'b1;
    end
    #3;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst%0d_valid", d), 32'(vld_a[d]), 32'd0);
      check($sformatf("rst%0d_busy", d), 32'(bz_a[d]), 32'd0);
      check($sformatf("rst%0d_data", d), 32'(dat_a[d]), 32'd0);
    end
    step(3);
    rst_n = 1'b1;
    step(4);

    vecs[0] = '{0, 9'h0A5, 1'b0, 1'b0, '0};
    vecs[1] = '{1, 9'h035, 1'b0, 1'b0, '0};
    vecs[2] = '{1, 9'h035, 1'b1, 1'b0, '0};
    vecs[3] = '{0, 9'h000, 1'b0, 1'b0, '0};
    vecs[4] = '{0, 9'h0FF, 1'b0, 1'b0, '0};
    vecs[5] = '{2, 9'h03C, 1'b0, 1'b0, '0};
    vecs[6] = '{1, 9'h07F, 1'b0, 1'b0, '0};
    vecs[7] = '{0, 9'h05A, 1'b0, 1'b1, '0};
    for (int i = 8; i < 14; i++) begin
      vecs[i].d    = int'($urandom_range(0, 2));
      vecs[i].data = 9'($urandom_range(0, 511));
      vecs[i].flip = 1'($urandom_range(0, 1));
      vecs[i].bad  = ($urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 14; i++)
      vecs[i].exp = model(vecs[i].d, vecs[i].data, vecs[i].flip, vecs[i].bad);

    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(vecs[i].exp);
      send_frame(vecs[i].d, vecs[i].data, vecs[i].flip, vecs[i].bad, 1'b0);
      step(8);
      wait_got(vecs[i].d, 64, ok);
      check($sformatf("vec%0d_arrived", i), 32'(ok), 32'd1);
      e = exp_q.pop_front();
      if (ok) check($sformatf("vec%0d_word", i), 32'(got_q[vecs[i].d].pop_front()), 32'(e));
      check($sformatf("vec%0d_valid_low", i), 32'(vld_a[vecs[i].d]), 32'd0);
      check($sformatf("vec%0d_idle", i), 32'(bz_a[vecs[i].d]), 32'd0);
    end

    // Short low glitch on an idle line must be rejected.
    rxd_a[0] = 1'b0;
    step(5);
    rxd_a[0] = 1'b1;
    step(3);
    check("glitch_busy_high", 32'(bz_a[0]), 32'd1);
    step(8);
    check("glitch_busy_low", 32'(bz_a[0]), 32'd0);
    check("glitch_state_idle", 32'(st_a[0]), 32'(ST_IDLE));
    check("glitch_no_word", 32'(got_q[0].size()), 32'd0);
    send_frame(0, 9'h096, 1'b0, 1'b0, 1'b0);
    expect_word("after_glitch", 0, model(0, 9'h096, 1'b0, 1'b0));

    // 8N2 with a low second stop bit: break wait until the line returns high.
    send_frame(2, 9'h03C, 1'b0, 1'b1, 1'b1);
    step(40);
    check("brk_state", 32'(st_a[2]), 32'(ST_BRK_WAIT));
    check("brk_busy", 32'(bz_a[2]), 32'd1);
    expect_word("brk", 2, model(2, 9'h03C, 1'b0, 1'b1));
    rxd_a[2] = 1'b1;
    step(6);
    check("brk_exit_busy", 32'(bz_a[2]), 32'd0);
    check("brk_exit_state", 32'(st_a[2]), 32'(ST_IDLE));
    send_frame(2, 9'h055, 1'b0, 1'b0, 1'b0);
    expect_word("after_brk", 2, model(2, 9'h055, 1'b0, 1'b0));

    // Stalled consumer: the second word is dropped with a single overrun pulse.
    rdy_a[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 1'b0, 1'b0);
    step(4);
    check("ovr_first_valid", 32'(vld_a[0]), 32'd1);
    check("ovr_first_data", 32'(dat_a[0]), 32'h11);
    send_frame(0, 9'h022, 1'b0, 1'b0, 1'b0);
    step(4);
    check("ovr_pulse_count", 32'(ovr_cnt[0]), 32'd1);
    check("ovr_kept_valid", 32'(vld_a[0]), 32'd1);
    check("ovr_kept_data", 32'(dat_a[0]), 32'h11);
    check("ovr_none_taken", 32'(got_q[0].size()), 32'd0);
    rdy_a[0] = 1'b1;
    step(2);
    check("ovr_taken_count", 32'(got_q[0].size()), 32'd1);
    if (got_q[0].size() > 0) check("ovr_taken_word", 32'(got_q[0].pop_front()), 32'h011);
    check("ovr_valid_cleared", 32'(vld_a[0]), 32'd0);

    // Reset in the middle of the data bits of 0xFF.
    rxd_a[0] = 1'b0;
    step(OVERSAMPLE);
    rxd_a[0] = 1'b1;
    step(3 * OVERSAMPLE);
    check("midrst_busy_before", 32'(bz_a[0]), 32'd1);
    rst_n = 1'b0;
    #2;
    check("midrst_valid", 32'(vld_a[0]), 32'd0);
    check("midrst_data", 32'(dat_a[0]), 32'd0);
    check("midrst_flags", 32'({fe_a[0], pe_a[0], ov_a[0]}), 32'd0);
    check("midrst_busy", 32'(bz_a[0]), 32'd0);
    check("midrst_state", 32'(st_a[0]), 32'(ST_IDLE));
    step(3);
    rst_n = 1'b1;
    step(8 * OVERSAMPLE);
    check("midrst_no_word", 32'(got_q[0].size()), 32'd0);
    send_frame(0, 9'h00F, 1'b0, 1'b0, 1'b0);
    expect_word("after_rst", 0, model(0, 9'h00F, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, legal range 5..9, data bits per frame.
REQ-002 SHALL provide parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-003 SHALL provide parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-004 SHALL provide port bclk  in  1  clock at 16x baud rate.
REQ-005 SHALL provide port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port rxd  in  1  asynchronous serial input, idle high.
REQ-007 SHALL provide port m_valid  out  1  received word available.
REQ-008 SHALL provide port m_ready  in  1  consumer accepts the word.
REQ-009 SHALL provide port m_data  out  DATA_BITS  received word, LSB received first.
REQ-010 SHALL provide port frame_err  out  1  stop bit sampled low; qualified by m_valid.
REQ-011 SHALL provide port parity_err  out  1  parity mismatch; qualified by m_valid; 0 when PARITY=0.
REQ-012 SHALL provide port overrun  out  1  one-cycle pulse: a completed frame was dropped.
REQ-013 SHALL provide port busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL pass rxd through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rxs.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP and BRK_WAIT.
REQ-016 SHALL run a 4-bit tick counter, cleared on every state entry and wrapping 15->0; one bit period is 16 ticks.
REQ-017 SHALL leave IDLE for START on the first cycle rxs=0 (tick 0 = that cycle).
REQ-018 SHALL take each bit value as a majority vote of rxs at ticks 7, 8 and 9 of that bit.
REQ-019 SHALL return from START to IDLE at tick 9 when the vote is 1 (glitch rejection), emitting no output.
REQ-020 SHALL shift DATA_BITS bits LSB-first in DATA, each bit advancing at tick 15; PARITY follows only when PARITY!=0.
REQ-021 SHALL flag parity_err when XOR(data, parity bit) is 0 for odd parity or 1 for even parity.
REQ-022 SHALL evaluate each stop bit at tick 9; any stop vote of 0 sets frame_err.
REQ-023 SHALL complete the frame at tick 9 of the last stop bit, skipping its remaining ticks for resynchronization.
REQ-024 SHALL go to IDLE on completion with good stop bits, and to BRK_WAIT when frame_err is set.
REQ-025 SHALL hold BRK_WAIT until rxs=1, then go to IDLE.
REQ-026 SHALL register m_data, frame_err and parity_err, and set m_valid, on the cycle after completion.
REQ-027 SHALL keep m_valid and the flags stable until a cycle with m_valid&&m_ready, then clear m_valid the next cycle.
REQ-028 SHALL, when completion occurs while m_valid=1 and m_ready=0, drop the new word, keep the old word, and pulse overrun for one cycle.
REQ-029 SHALL accept the new word without overrun when completion coincides with a handshake (m_valid&&m_ready).
REQ-030 SHALL not stall reception on m_ready; rx continues regardless.

Reset
REQ-031 SHALL on rst_n=0 asynchronously set state IDLE, tick 0, shift register 0, synchronizer flops 1, m_valid 0, m_data 0, frame_err 0, parity_err 0, overrun 0, busy 0.
REQ-032 SHALL abort any frame in progress on reset mid-frame and emit no word for it.

Structure
REQ-033 SHALL place the state enum, parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN) and the oversample constant 16 in shared package uart_pkg.
REQ-034 SHALL place the synchronizer and the 3-sample majority voter in sub-module uart_rx_sampler.

Verification
REQ-035 SHALL test 8N1 0xA5 with m_ready=1 -> m_valid pulse, m_data=0xA5, both error flags 0.
REQ-036 SHALL test 7E1 with PARITY=2: 0x35 with correct parity bit 0 -> parity_err=0; the same frame with the parity bit flipped -> parity_err=1.
REQ-037 SHALL test a 5-tick low glitch on idle rxd -> no m_valid, busy falls after 10 cycles, ready for the next frame.
REQ-038 SHALL test 8N2 0x3C with second stop bit low -> frame_err=1 and BRK_WAIT held until rxd high; a following 0x55 is received clean.
REQ-039 SHALL test m_ready=0 with 0x11 then 0x22 -> overrun pulses once and m_data stays 0x11 until the handshake.
REQ-040 SHALL test rst_n asserted mid-DATA on 0xFF -> all outputs reset, no word emitted, and the next 0x0F is received correctly.
